// File: rtl/mesh_noc_pkg.sv
// Shared constants and types for the mesh router: flit layout, requester
// indices and small helpers used by the per-port output arbiters.
package mesh_noc_pkg;

  localparam int FLIT_W = 34;
  localparam int N_REQ  = 9;
  localparam int CNT_W  = 16;
  localparam int IDX_W  = 4;

  localparam int FLIT_VALID_BIT = 33;
  localparam int FLIT_ROW_HI    = 32;
  localparam int FLIT_ROW_LO    = 31;
  localparam int FLIT_COL_HI    = 30;
  localparam int FLIT_COL_LO    = 29;

  localparam int REQ_INJ = 0;
  localparam int REQ_N   = 1;
  localparam int REQ_S   = 2;
  localparam int REQ_E   = 3;
  localparam int REQ_W   = 4;
  localparam int REQ_NE  = 5;
  localparam int REQ_NW  = 6;
  localparam int REQ_SE  = 7;
  localparam int REQ_SW  = 8;

  typedef logic [FLIT_W-1:0] flit_t;
  typedef logic [IDX_W-1:0]  req_idx_t;

  // Next round-robin position after idx among n requesters.
  function automatic req_idx_t wrap_inc(input req_idx_t idx, input int n);
    req_idx_t r;
    if (int'(idx) >= n - 1) r = '0;
    else                    r = idx + 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/mesh_port_arbiter_if.sv
// Bundle of the arbiter's requester, output-link and statistics signals.
interface mesh_port_arbiter_if;
  import mesh_noc_pkg::*;

  // Handshake: requester i offers req_flit[i] with its valid bit set and holds
  // it until req_ready[i] is seen high at a clock edge (that edge consumes it).
  // out_flit is taken downstream at any edge where out_flit valid and out_ready
  // are both high; otherwise it stays put.
  logic [N_REQ*FLIT_W-1:0] req_flit;
  logic [N_REQ-1:0]        req_ready;
  flit_t                   out_flit;
  logic                    out_ready;
  req_idx_t                grant_id;
  logic                    stat_clr;
  logic [CNT_W-1:0]        grant_cnt;
  logic [CNT_W-1:0]        conflict_cnt;
  req_idx_t                dbg_ptr;

  modport slave (
    input  req_flit, out_ready, stat_clr,
    output req_ready, out_flit, grant_id, grant_cnt, conflict_cnt, dbg_ptr
  );

  modport master (
    output req_flit, out_ready, stat_clr,
    input  req_ready, out_flit, grant_id, grant_cnt, conflict_cnt, dbg_ptr
  );

endinterface

// File: rtl/mesh_port_arbiter_rr_pick.sv
// Combinational round-robin pick: rotate requests so ptr lands at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_pick
  import mesh_noc_pkg::*;
#(
  parameter int N = N_REQ,
  parameter int W = IDX_W
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] win,
  output logic         any
);

  logic [N-1:0] rot;
  logic [W-1:0] off;
  logic [W:0]   sum;

  always_comb begin
    rot = N'({req, req} >> ptr);
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = W'(i);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
    win = sum[W-1:0];
    any = |req;
    gnt = any ? (N'(1) << win) : '0;
  end

endmodule

// File: rtl/mesh_port_arbiter.sv
// Output-link arbiter for one mesh router port: round-robin among inject and
// neighbour requesters into a single output register, with grant statistics.
module mesh_port_arbiter #(
  parameter int N_REQ  = mesh_noc_pkg::N_REQ,
  parameter int FLIT_W = mesh_noc_pkg::FLIT_W,
  parameter int CNT_W  = mesh_noc_pkg::CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  mesh_port_arbiter_if.slave   bus
);
  import mesh_noc_pkg::*;

  logic [N_REQ-1:0]  req_vec;
  logic [N_REQ-1:0]  gnt;
  req_idx_t          win;
  logic              any_req;
  logic              slot_free;
  logic              load;
  logic              multi_req;
  logic [FLIT_W-1:0] sel_flit;

  logic [FLIT_W-1:0] out_flit_q, out_flit_d;
  req_idx_t          grant_id_q, grant_id_d;
  req_idx_t          ptr_q, ptr_d;
  logic [CNT_W-1:0]  grant_cnt_q, grant_cnt_d;
  logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    req_vec = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_vec[i] = bus.req_flit[i*FLIT_W + FLIT_VALID_BIT];
    end
  end

  rr_pick #(.N(N_REQ), .W(IDX_W)) u_pick (
    .req (req_vec),
    .ptr (ptr_q),
    .gnt (gnt),
    .win (win),
    .any (any_req)
  );

  // A full slot that is being drained this cycle counts as free: pass-through.
  assign slot_free = !out_flit_q[FLIT_VALID_BIT] || bus.out_ready;
  assign load      = any_req && slot_free;
  assign multi_req = |(req_vec & (req_vec - 1'b1));
  assign sel_flit  = bus.req_flit[int'(win)*FLIT_W +: FLIT_W];

  always_comb begin
    out_flit_d = out_flit_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    if (load) begin
      out_flit_d = sel_flit;
      grant_id_d = win;
      ptr_d      = wrap_inc(win, N_REQ);
    end else if (bus.out_ready) begin
      out_flit_d = '0;
    end
  end

  // Clear beats increment; both counters stick at all-ones.
  always_comb begin
    grant_cnt_d    = grant_cnt_q;
    conflict_cnt_d = conflict_cnt_q;
    if (bus.stat_clr) begin
      grant_cnt_d    = '0;
      conflict_cnt_d = '0;
    end else begin
      if (load && !(&grant_cnt_q))         grant_cnt_d    = grant_cnt_q + 1'b1;
      if (multi_req && !(&conflict_cnt_q)) conflict_cnt_d = conflict_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_flit_q     <= '0;
      grant_id_q     <= '0;
      ptr_q          <= '0;
      grant_cnt_q    <= '0;
      conflict_cnt_q <= '0;
    end else begin
      out_flit_q     <= out_flit_d;
      grant_id_q     <= grant_id_d;
      ptr_q          <= ptr_d;
      grant_cnt_q    <= grant_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  // Gated by rst so nothing is consumed in a cycle whose edge discards state.
  assign bus.req_ready    = (rst || !slot_free) ? '0 : gnt;
  assign bus.out_flit     = out_flit_q;
  assign bus.grant_id     = grant_id_q;
  assign bus.grant_cnt    = grant_cnt_q;
  assign bus.conflict_cnt = conflict_cnt_q;
  assign bus.dbg_ptr      = ptr_q;

endmodule

// File: tb/tb_mesh_port_arbiter.sv
// Directed bench for mesh_port_arbiter with a cycle-level reference model.
module tb_mesh_port_arbiter;
  import mesh_noc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic chk_en  = 1'b1;

  mesh_port_arbiter_if bus();

  mesh_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  flit_t            m_out = '0;
  int               m_gid = 0;
  int               m_ptr = 0;
  int               m_gc  = 0;
  int               m_cc  = 0;
  localparam int    CMAX  = (1 << CNT_W) - 1;

  function automatic int n_pending();
    int c = 0;
    for (int i = 0; i < N_REQ; i++) if (bus.req_flit[i*FLIT_W + FLIT_VALID_BIT]) c++;
    return c;
  endfunction

  // First requesting index at or after p, circularly; -1 when none.
  function automatic int find_win(input int p);
    for (int k = 0; k < N_REQ; k++) begin
      int idx = (p + k) % N_REQ;
      if (bus.req_flit[idx*FLIT_W + FLIT_VALID_BIT]) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int  w;
    bit  free, ld;
    if (rst) begin
      m_out = '0; m_gid = 0; m_ptr = 0; m_gc = 0; m_cc = 0;
    end else begin
      w    = find_win(m_ptr);
      free = !m_out[FLIT_VALID_BIT] || bus.out_ready;
      ld   = (w >= 0) && free;
      if (bus.stat_clr) m_cc = 0;
      else if (n_pending() >= 2 && m_cc < CMAX) m_cc++;
      if (bus.stat_clr) m_gc = 0;
      else if (ld && m_gc < CMAX) m_gc++;
      if (ld) begin
        m_out = bus.req_flit[w*FLIT_W +: FLIT_W];
        m_gid = w;
        m_ptr = (w + 1) % N_REQ;
      end else if (bus.out_ready) begin
        m_out = '0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [N_REQ-1:0] exp_rdy;
    int w;
    if (chk_en) begin
      exp_rdy = '0;
      w = find_win(m_ptr);
      if (!rst && w >= 0 && (!m_out[FLIT_VALID_BIT] || bus.out_ready)) exp_rdy[w] = 1'b1;
      chk("m_req_ready",    64'(bus.req_ready),    64'(exp_rdy));
      chk("m_out_flit",     64'(bus.out_flit),     64'(m_out));
      chk("m_grant_id",     64'(bus.grant_id),     64'(m_gid));
      chk("m_ptr",          64'(bus.dbg_ptr),      64'(m_ptr));
      chk("m_grant_cnt",    64'(bus.grant_cnt),    64'(m_gc));
      chk("m_conflict_cnt", 64'(bus.conflict_cnt), 64'(m_cc));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input flit_t f);
    bus.req_flit[i*FLIT_W +: FLIT_W] = f;
  endtask

  task automatic clr_reqs();
    bus.req_flit = '0;
  endtask

  function automatic flit_t mk(input int i);
    return {1'b1, 33'(i + 16)};
  endfunction

  // ---------------- directed stimulus ----------------
  logic [3:0] exp_q[$];
  int         n_fill;

  initial begin
    rst = 1'b1;
    bus.out_ready = 1'b1;
    bus.stat_clr  = 1'b0;
    clr_reqs();
    set_req(0, mk(0));
    tick(); tick();
    at_neg();
    chk("rst_ready",    64'(bus.req_ready), 64'h0);
    chk("rst_out_flit", 64'(bus.out_flit),  64'h0);
    chk("rst_grant_id", 64'(bus.grant_id),  64'h0);
    tick();
    clr_reqs();
    rst = 1'b0;
    tick();

    // single request from requester 3
    set_req(3, 34'h2_A000_0001);
    at_neg();
    chk("single_ready", 64'(bus.req_ready), 64'h008);
    tick();
    clr_reqs();
    at_neg();
    chk("single_flit", 64'(bus.out_flit), 64'h2_A000_0001);
    chk("single_gid",  64'(bus.grant_id), 64'd3);
    chk("single_ptr",  64'(bus.dbg_ptr),  64'd4);

    // drain
    tick();
    at_neg();
    chk("drain_flit", 64'(bus.out_flit), 64'h0);
    chk("drain_gid",  64'(bus.grant_id), 64'd3);

    // full contention starting at ptr 7
    tick();
    set_req(6, mk(6));
    tick();
    clr_reqs();
    tick();
    for (int i = 0; i < N_REQ; i++) set_req(i, mk(i));
    exp_q = '{4'd7, 4'd8, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    for (int k = 0; k < N_REQ; k++) begin
      tick();
      at_neg();
      chk("rr_order", 64'(bus.grant_id), 64'(exp_q.pop_front()));
    end
    chk("rr_conflict", 64'(bus.conflict_cnt), 64'd9);
    chk("rr_grants",   64'(bus.grant_cnt),    64'd11);
    tick();
    clr_reqs();

    // backpressure with requester 2 holding the slot
    tick();
    set_req(2, mk(2));
    tick();
    clr_reqs();
    bus.out_ready = 1'b0;
    set_req(1, mk(1));
    set_req(5, mk(5));
    for (int k = 0; k < 5; k++) begin
      at_neg();
      chk("bp_ready", 64'(bus.req_ready), 64'h0);
      chk("bp_flit",  64'(bus.out_flit),  64'(mk(2)));
      chk("bp_gid",   64'(bus.grant_id),  64'd2);
      chk("bp_ptr",   64'(bus.dbg_ptr),   64'd3);
      tick();
    end
    bus.out_ready = 1'b1;
    at_neg();
    chk("bp_release_ready", 64'(bus.req_ready), 64'h020);
    tick();
    set_req(5, '0);
    at_neg();
    chk("bp_next_flit", 64'(bus.out_flit), 64'(mk(5)));
    chk("bp_next_gid",  64'(bus.grant_id), 64'd5);
    tick();
    clr_reqs();
    tick();

    // grant counter saturation and clear
    set_req(0, mk(0));
    n_fill = 16'hFFFE - m_gc;
    repeat (n_fill) @(posedge clk);
    #1;
    at_neg();
    chk("sat_fffe", 64'(bus.grant_cnt), 64'hFFFE);
    tick(); tick(); tick();
    at_neg();
    chk("sat_ffff", 64'(bus.grant_cnt), 64'hFFFF);
    tick();
    bus.stat_clr = 1'b1;
    tick();
    bus.stat_clr = 1'b0;
    at_neg();
    chk("clr_grant",    64'(bus.grant_cnt),    64'h0);
    chk("clr_conflict", 64'(bus.conflict_cnt), 64'h0);

    // reset while the slot is full and requests are pending
    tick();
    clr_reqs();
    set_req(4, mk(4));
    set_req(6, mk(6));
    bus.out_ready = 1'b0;
    tick();
    rst = 1'b1;
    at_neg();
    chk("mid_rst_ready", 64'(bus.req_ready), 64'h0);
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    at_neg();
    chk("post_rst_flit",  64'(bus.out_flit),  64'h0);
    chk("post_rst_gid",   64'(bus.grant_id),  64'h0);
    chk("post_rst_ptr",   64'(bus.dbg_ptr),   64'h0);
    chk("post_rst_gcnt",  64'(bus.grant_cnt), 64'h0);
    chk("post_rst_ready", 64'(bus.req_ready), 64'h010);
    tick();
    at_neg();
    chk("post_rst_win",  64'(bus.grant_id), 64'd4);
    chk("post_rst_data", 64'(bus.out_flit), 64'(mk(4)));
    tick();
    clr_reqs();
    tick(); tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mesh_port_arbiter.md
# mesh_port_arbiter

Round-robin arbiter and output register for one output link of `mesh_router`. It shares a single 34-bit outgoing link among the inject path and the eight incoming neighbour links. It replaces the current last-writer-wins overwrite with a lossless valid/ready handshake, and keeps saturating grant and contention statistics. One instance sits on each of the router's eight output ports.

## Interface
Parameters:
- `N_REQ`, 9, number of requesters; index 0 is inject, 1..8 are n, s, e, w, ne, nw, se, sw.
- `FLIT_W`, 34, flit width; bit 33 is valid, [32:31] is target row, [30:29] is target col, [28:0] is payload.
- `CNT_W`, 16, width of each statistics counter.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req_flit`  in  N_REQ*FLIT_W  requester flits, requester i at [i*FLIT_W +: FLIT_W]; requester i is requesting when its bit 33 is 1.
- `req_ready`  out  N_REQ  one-hot or zero; requester i's flit is consumed this cycle when its request and `req_ready[i]` are both 1.
- `out_flit`  out  FLIT_W  registered output flit; bit 33 is the output valid.
- `out_ready`  in  1  downstream accepts `out_flit` this cycle when `out_ready` and `out_flit[33]` are both 1.
- `grant_id`  out  4  index of the requester whose flit currently occupies `out_flit`.
- `stat_clr`  in  1  synchronous clear of both counters.
- `grant_cnt`  out  CNT_W  saturating count of accepted flits.
- `conflict_cnt`  out  CNT_W  saturating count of cycles with two or more requests pending.

## Operation
- Requesters hold a flit stable, with bit 33 set, until it is consumed. Dropping the request before consumption is legal; the flit is simply not sent.
- Slot free: `slot_free = !out_flit[33] || out_ready`.
- Arbitration:
  - The winner is the first requesting index at or after `ptr`, searching `ptr, ptr+1, …, N_REQ-1, 0, …`.
  - `req_ready[winner] = slot_free`. All other `req_ready` bits are 0.
  - `req_ready` is combinational from `req_flit`, `ptr`, `out_flit` and `out_ready`.
- On a load, when some request is pending and `slot_free` is 1:
  - `out_flit <= req_flit[winner]`, `grant_id <= winner`.
  - `ptr <= winner+1`, wrapping N_REQ-1 to 0.
  - `grant_cnt` increments.
- When no load happens and `out_ready` is 1, the slot is drained: `out_flit <= 0`, and `grant_id` holds its value.
- When `out_flit[33]` is 1 and `out_ready` is 0:
  - `out_flit`, `grant_id` and `ptr` all hold.
  - All `req_ready` bits are 0.
- `ptr` changes only on a load, so a requester that loses the arbitration keeps its priority position.
- Contention: `conflict_cnt` increments in every cycle where the number of pending requests is at least 2, whether or not a load occurs.
- Both counters saturate at all-ones, with no wrap. If `stat_clr` and an increment occur in the same cycle, the clear wins and the counter becomes 0.
- Routing decisions are not made here. The router supplies only flits already destined for this port.

## Timing
- Reset values:
  - `out_flit` = 0, `grant_id` = 0, `ptr` = 0.
  - `grant_cnt` = 0, `conflict_cnt` = 0.
  - `req_ready` = 0 while `rst` is high.
- Latency: 1 cycle from a consumed request to `out_flit[33]` = 1.
- Throughput: 1 flit per cycle. A load and a downstream accept in the same cycle are a pass-through with no bubble.
- Fairness: with every requester continuously requesting and `out_ready` tied to 1, each requester is granted exactly once in any N_REQ consecutive loads.
- Reset asserted mid-operation: a flit held in `out_flit` is discarded, no `req_ready` is asserted in that cycle, and no flit is lost from any requester.

## Structure
- The shared package `mesh_noc_pkg` holds:
  - `FLIT_W`, `N_REQ`;
  - the flit field positions `FLIT_VALID_BIT=33`, `FLIT_ROW_HI/LO=32/31`, `FLIT_COL_HI/LO=30/29`;
  - the requester index constants `REQ_INJ=0`, `REQ_N=1` … `REQ_SW=8`.
- The sub-module `rr_pick` is combinational. It takes the request vector and `ptr` and returns the one-hot grant, the winner index and an `any` flag, using rotate, priority-encode and un-rotate.
- The top level holds `ptr`, the output register and the counters.

## Test plan
- Single request: requester 3 presents 0x2_A000_0001 with `out_ready` = 1 → `req_ready` = 0x008; the next cycle `out_flit` = 0x2_A000_0001 and `grant_id` = 3; `ptr` becomes 4.
- Full contention with wrap: all 9 requesters continuously requesting, `ptr` = 7, `out_ready` = 1 → grant order 7, 8, 0, 1, …, 6, one per cycle; `conflict_cnt` = 9 after 9 cycles.
- Backpressure: `out_flit` valid from requester 2, `out_ready` = 0 for 5 cycles with requests pending → `req_ready` = 0 and `out_flit`, `ptr` and `grant_id` unchanged for those 5 cycles; when `out_ready` rises, the next winner loads in the same cycle.
- Drain: single request consumed, then no requests with `out_ready` = 1 → `out_flit` = 0 one cycle after the accept; `grant_id` keeps its last value.
- Saturation and clear: force `grant_cnt` to 0xFFFE, then perform 3 loads → 0xFFFF; assert `stat_clr` during a load → 0.
- Reset mid-operation: assert `rst` while `out_flit` is valid and requests are pending → the next cycle all outputs are 0, `ptr` = 0, and the first grant after reset goes to the lowest-index requester.
